// File: rtl/div_unit_if.sv
// div_unit_if: request/result bundle between the execute stage and the divider.
//   start_i  request a division (sampled only while busy_o=0)
//   op_i     00 div, 01 divu, 10 rem, 11 remu
//   a_i/b_i  dividend / divisor
//   flush_i  abort any operation in progress
//   busy_o   divider occupied; the pipeline stalls on it
//   valid_o  one-cycle pulse, res_o holds a new result
//   res_o    registered result, held until the next valid_o
interface div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [1:0]            op_i;
    logic [DATA_WIDTH-1:0] a_i;
    logic [DATA_WIDTH-1:0] b_i;
    logic                  flush_i;
    logic                  busy_o;
    logic                  valid_o;
    logic [DATA_WIDTH-1:0] res_o;
    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  busy_o, valid_o, res_o
    );
    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output busy_o, valid_o, res_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M div/divu/rem/remu.
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    div_unit_if.slave: start_i/op_i/a_i/b_i/flush_i in, busy_o/valid_o/res_o out
// Division by zero and signed overflow bypass the iteration and finish in one cycle.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input logic       clk_i,
    input logic       rst_i,
    div_unit_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t         state_q;
    logic [W:0]     rem_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   div_q;
    logic [CW-1:0]  cnt_q;
    logic           sgn_quo_q;
    logic           sgn_rem_q;
    logic           is_rem_q;
    logic           busy_q;
    logic           valid_q;
    logic [W-1:0]   res_q;
    logic           is_signed;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;
    logic           b_zero;
    logic           ovf;
    logic [W-1:0]   fast_res;
    logic [W:0]     rem_sh;
    logic           ge;
    logic [W:0]     rem_d;
    logic [W-1:0]   quo_d;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   res_fix;
    always_comb begin
        is_signed = ~bus.op_i[0];
        a_neg     = is_signed & bus.a_i[W-1];
        b_neg     = is_signed & bus.b_i[W-1];
        // two's complement negation of INT_MIN yields INT_MIN, which is the correct unsigned magnitude
        a_abs     = a_neg ? -bus.a_i : bus.a_i;
        b_abs     = b_neg ? -bus.b_i : bus.b_i;
        b_zero    = bus.b_i == '0;
        ovf       = is_signed && bus.a_i == {1'b1, {(W-1){1'b0}}} && bus.b_i == '1;
        fast_res  = b_zero ? (bus.op_i[1] ? bus.a_i : '1) : (bus.op_i[1] ? '0 : bus.a_i);
        // dividend bits shift out of the quotient register into the partial remainder
        rem_sh    = {rem_q[W-1:0], quo_q[W-1]};
        // bit W of the stored remainder is always clear after a step; folding it in keeps the compare total
        ge        = rem_q[W] | (rem_sh >= {1'b0, div_q});
        rem_d     = ge ? rem_sh - {1'b0, div_q} : rem_sh;
        quo_d     = {quo_q[W-2:0], ge};
        quo_fix   = sgn_quo_q ? -quo_d : quo_d;
        rem_fix   = sgn_rem_q ? -rem_d[W-1:0] : rem_d[W-1:0];
        res_fix   = is_rem_q ? rem_fix : quo_fix;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            res_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start_i && !bus.flush_i) begin
                        is_rem_q  <= bus.op_i[1];
                        sgn_quo_q <= a_neg ^ b_neg;
                        sgn_rem_q <= a_neg;
                        div_q     <= b_abs;
                        quo_q     <= a_abs;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        if (b_zero || ovf) begin
                            res_q   <= fast_res;
                            valid_q <= 1'b1;
                            state_q <= FIX;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CW'(1);
                        // the final step's result is corrected and registered on the way into FIX
                        if (cnt_q == CW'(W - 1)) begin
                            res_q   <= res_fix;
                            valid_q <= 1'b1;
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign bus.busy_o  = busy_q;
    assign bus.valid_o = valid_q;
    assign bus.res_o   = res_q;
endmodule
